// File: rtl/addsub_hex_display_pkg.sv
// Shared constants and helpers for the add/sub hex display block:
// seven-segment patterns, the blank pattern and the digit-count rule.
package addsub_disp_pkg;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // All segments off; the digit's anode stays asserted.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Digits needed to show {cout, result}: ceil((width + 1) / 4).
  function automatic int min_digits(input int width);
    return (width + 4) / 4;
  endfunction

endpackage

// File: rtl/addsub_hex_display_hex_to_7seg.sv
// Combinational 4-bit to active-low seven-segment decoder.
module hex_to_7seg
  import addsub_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/addsub_hex_display.sv
// Registered adder/subtractor whose {cout, result} is scanned digit by
// digit onto a common-anode hexadecimal seven-segment display.
module addsub_hex_display
  import addsub_disp_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              m,
  input  logic              load,
  output logic [WIDTH-1:0]  result,
  output logic              cout,
  output logic              ovf,
  output logic              valid,
  output logic [6:0]        segments,
  output logic [DIGITS-1:0] anode
);

  localparam int DW    = DIGITS * 4;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);

  // Parameter sanity, rejected at elaboration.
  if (WIDTH < 4) begin : g_bad_width
    $error("addsub_hex_display: WIDTH must be at least 4");
  end
  if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
    $error("addsub_hex_display: DIGITS too small to show {cout, result}");
  end
  if (REFRESH_DIV < 2) begin : g_bad_refresh
    $error("addsub_hex_display: REFRESH_DIV must be at least 2");
  end

  // Operand stage
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             m_q;
  logic             pend;

  // Latch operands on the load strobe; pend marks an operation in flight.
  // NOTE: all registered state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q  <= '0;
      b_q  <= '0;
      m_q  <= 1'b0;
      pend <= 1'b0;
    end else begin
      pend <= load;
      if (load) begin
        a_q <= a;
        b_q <= b;
        m_q <= m;
      end
    end
  end

  // Arithmetic: A + (B ^ {m}) + m, one bit wider to keep the carry.
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             sum_ovf;

  assign b_eff   = b_q ^ {WIDTH{m_q}};
  assign sum     = {1'b0, a_q} + {1'b0, b_eff} + (WIDTH + 1)'(m_q);
  assign sum_ovf = (a_q[WIDTH-1] == b_eff[WIDTH-1]) &&
                   (sum[WIDTH-1] != a_q[WIDTH-1]);

  // Result register; valid pulses for exactly the cycle the result updates.
  always_ff @(posedge clk) begin
    if (!reset) begin
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      valid  <= 1'b0;
    end else begin
      valid <= pend;
      if (pend) begin
        result <= sum[WIDTH-1:0];
        cout   <= sum[WIDTH];
        ovf    <= sum_ovf;
      end
    end
  end

  // Scan timing
  logic [CNT_W-1:0] refresh_cnt;
  logic [IDX_W-1:0] idx;

  // Refresh counter wraps at REFRESH_DIV-1 and steps the digit index.
  always_ff @(posedge clk) begin
    if (!reset) begin
      refresh_cnt <= '0;
      idx         <= '0;
    end else if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      idx         <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Digit selection and leading-zero blanking
  logic [DW-1:0]     disp_val;
  logic [DIGITS-1:0] blank;
  logic [3:0]        cur_nibble;
  logic              cur_blank;
  logic              upper_zero;
  logic [6:0]        dec_seg;

  assign disp_val = DW'({cout, result});

  // Find blankable digits (all nibbles at and above are zero) and pick the active one.
  // NOTE: every variable gets a default before the loops so no path infers a latch.
  always_comb begin
    blank      = '0;
    upper_zero = 1'b1;
    cur_nibble = 4'h0;
    cur_blank  = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (disp_val[4*i +: 4] == 4'h0);
      blank[i]   = upper_zero;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nibble = disp_val[4*i +: 4];
        cur_blank  = blank[i];
      end
    end
  end

  hex_to_7seg u_hex_to_7seg (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

  // Registered display outputs: active digit's pattern and its one-hot-low anode.
  always_ff @(posedge clk) begin
    if (!reset) begin
      segments <= SEG_BLANK;
      anode    <= '1;
    end else begin
      segments <= (BLANK_LZ && cur_blank) ? SEG_BLANK : dec_seg;
      anode    <= ~(DIGITS'(1) << idx);
    end
  end

endmodule
